// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg -- configurable UART receiver.
//
// Receives asynchronous serial frames (start, DATA_BITS data LSB first,
// optional parity, STOP_BITS stop bits) on i_in and emits one word per
// frame together with per-frame status flags.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_in         serial line, idles high (asynchronous to i_clk)
//   o_data       received word (DATA_BITS wide), updated when a frame completes
//   o_valid      one-cycle pulse per completed frame
//   o_parity_err parity mismatch, qualified by o_valid
//   o_frame_err  stop bit sampled low, qualified by o_valid
//   o_break      all-zero frame including the failing stop bit, qualified by o_valid
//   o_busy       receiver is not idle
module uart_rx_cfg #(
  parameter int CLK_FREQ    = 12000000,
  parameter int BAUD        = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_in,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int H            = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int IW           = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LO   = CW'(H - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(H);
  localparam logic [CW-1:0] CNT_HI   = CW'(H + 1);
  localparam logic [CW-1:0] CNT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  generate
    if (CLKS_PER_BIT < 8) begin : g_bad_rate
      $error("uart_rx_cfg: CLK_FREQ/BAUD must be at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
      $error("uart_rx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("uart_rx_cfg: SYNC_STAGES must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY_BIT, STOP, WAIT_HIGH
  } state_t;

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic [CW-1:0]          bit_cnt_reg;
  logic [IW-1:0]          idx_reg;
  logic                   stop_idx_reg;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   smp_a_reg, smp_b_reg;
  logic                   par_err_reg;
  logic                   any_one_reg;

  logic line, fall, maj, at_mid, at_end;
  logic frame_done, stop_bad;

  assign line   = sync_reg[SYNC_STAGES-1];
  assign fall   = prev_reg & ~line;
  // Third sample is the live synchronised line, so the vote resolves at H+1.
  assign maj    = (smp_a_reg & smp_b_reg) | (smp_a_reg & line) | (smp_b_reg & line);
  assign at_mid = (bit_cnt_reg == CNT_HI);
  assign at_end = (bit_cnt_reg == CNT_END);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:       if (fall) state_next = START;
      START: begin
        if (at_mid && maj)  state_next = IDLE;   // false start
        else if (at_end)    state_next = DATA;
      end
      DATA: begin
        if (at_end && idx_reg == IDX_LAST)
          state_next = (PARITY != 0) ? PARITY_BIT : STOP;
      end
      PARITY_BIT: if (at_end) state_next = STOP;
      STOP: begin
        // Decide at mid-bit and leave early so the next start edge is not missed.
        if (at_mid) begin
          if (!maj)                          state_next = WAIT_HIGH;
          else if (stop_idx_reg == STOP_LAST) state_next = IDLE;
        end
      end
      WAIT_HIGH:  if (line) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    stop_bad   = (state_reg == STOP) && at_mid && !maj;
    frame_done = (state_reg == STOP) && at_mid && (!maj || stop_idx_reg == STOP_LAST);
    o_busy     = (state_reg != IDLE);
  end

  // Synchroniser, bit timing, shift register and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_reg     <= '1;
      prev_reg     <= 1'b1;
      bit_cnt_reg  <= '0;
      idx_reg      <= '0;
      stop_idx_reg <= 1'b0;
      shift_reg    <= '0;
      smp_a_reg    <= 1'b1;
      smp_b_reg    <= 1'b1;
      par_err_reg  <= 1'b0;
      any_one_reg  <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], i_in};
      prev_reg <= line;
      if (bit_cnt_reg == CNT_LO)  smp_a_reg <= line;
      if (bit_cnt_reg == CNT_MID) smp_b_reg <= line;

      case (state_reg)
        IDLE: begin
          // The detection cycle is count 0 of the start bit.
          bit_cnt_reg  <= fall ? CW'(1) : '0;
          idx_reg      <= '0;
          stop_idx_reg <= 1'b0;
          if (fall) begin
            par_err_reg <= 1'b0;
            any_one_reg <= 1'b0;
          end
        end
        WAIT_HIGH: bit_cnt_reg <= '0;
        default:   bit_cnt_reg <= at_end ? '0 : bit_cnt_reg + CW'(1);
      endcase

      if (state_reg == DATA && at_mid) begin
        shift_reg[idx_reg] <= maj;
        any_one_reg        <= any_one_reg | maj;
      end
      if (state_reg == DATA && at_end && idx_reg != IDX_LAST)
        idx_reg <= idx_reg + IW'(1);

      if (state_reg == PARITY_BIT && at_mid) begin
        // XOR of data and parity bit is 1 for an odd count of ones.
        par_err_reg <= (PARITY == 1) ? ~(^shift_reg ^ maj) : (^shift_reg ^ maj);
        any_one_reg <= any_one_reg | maj;
      end

      // Only reached when a good stop bit was not the last one.
      if (state_reg == STOP && at_end)
        stop_idx_reg <= stop_idx_reg + 1'b1;

      o_valid      <= frame_done;
      o_parity_err <= frame_done & par_err_reg;
      o_frame_err  <= stop_bad;
      o_break      <= stop_bad & ~any_one_reg;
      if (frame_done) o_data <= shift_reg;
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
module tb_uart_rx_cfg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] rx;

  always #5 clk = ~clk;

  // Three receivers: 0 = 8N1, 1 = 8E1, 2 = 7E2; all 10 clocks per bit.
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic       w_valid[3], w_pe[3], w_fe[3], w_brk[3], w_busy[3];
  logic [8:0] w_data[3];

  uart_rx_cfg #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(1), .SYNC_STAGES(2)) u_8n1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in(rx[0]), .o_data(d0), .o_valid(w_valid[0]),
    .o_parity_err(w_pe[0]), .o_frame_err(w_fe[0]), .o_break(w_brk[0]), .o_busy(w_busy[0]));

  uart_rx_cfg #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(2),
                .STOP_BITS(1), .SYNC_STAGES(2)) u_8e1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in(rx[1]), .o_data(d1), .o_valid(w_valid[1]),
    .o_parity_err(w_pe[1]), .o_frame_err(w_fe[1]), .o_break(w_brk[1]), .o_busy(w_busy[1]));

  uart_rx_cfg #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(7), .PARITY(2),
                .STOP_BITS(2), .SYNC_STAGES(2)) u_7e2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in(rx[2]), .o_data(d2), .o_valid(w_valid[2]),
    .o_parity_err(w_pe[2]), .o_frame_err(w_fe[2]), .o_break(w_brk[2]), .o_busy(w_busy[2]));

  always_comb begin
    w_data[0] = {1'b0, d0};
    w_data[1] = {1'b0, d1};
    w_data[2] = {2'b00, d2};
  end

  // Frame monitor, sampled on the falling edge.
  int         vcnt[3]  = '{0, 0, 0};
  int         stray[3] = '{0, 0, 0};
  logic [8:0] ldata[3];
  logic       lpe[3], lfe[3], lbrk[3], busy_after[3];
  bit         pend[3] = '{0, 0, 0};

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (pend[k]) begin
        busy_after[k] <= w_busy[k];
        pend[k]       <= 1'b0;
      end
      if (w_valid[k] === 1'b1) begin
        vcnt[k]  <= vcnt[k] + 1;
        ldata[k] <= w_data[k];
        lpe[k]   <= w_pe[k];
        lfe[k]   <= w_fe[k];
        lbrk[k]  <= w_brk[k];
        pend[k]  <= 1'b1;
      end else if (w_pe[k] !== 1'b0 || w_fe[k] !== 1'b0 || w_brk[k] !== 1'b0) begin
        stray[k] <= stray[k] + 1;
      end
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bit time; optional inverted glitch at cycle 5 (mid-bit sample point).
  task automatic drive_bit(input int sel, input logic v, input bit glitch);
    for (int c = 0; c < 10; c++) begin
      rx[sel] = (glitch && c == 5) ? ~v : v;
      tick();
    end
  endtask

  task automatic send(input int sel, input logic [8:0] data, input int nbits,
                      input bit has_par, input logic par, input logic s0,
                      input logic s1, input int nstop, input bit glitch);
    drive_bit(sel, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(sel, data[i], glitch);
    if (has_par) drive_bit(sel, par, 1'b0);
    drive_bit(sel, s0, 1'b0);
    if (nstop == 2) drive_bit(sel, s1, 1'b0);
    rx[sel] = 1'b1;
    repeat (20) tick();
  endtask

  int base;

  initial begin
    rst_n = 1'b0;
    rx    = 3'b111;
    repeat (3) tick();
    check("rst_valid", 32'(w_valid[0]), 32'd0);
    check("rst_busy",  32'(w_busy[0]),  32'd0);
    check("rst_data",  32'(d0),         32'd0);
    check("rst_flags", {29'd0, w_pe[0], w_fe[0], w_brk[0]}, 32'd0);
    rst_n = 1'b1;
    repeat (5) tick();
    check("idle_busy", {29'd0, w_busy[0], w_busy[1], w_busy[2]}, 32'd0);

    // 1: 8N1 0x41
    base = vcnt[0];
    send(0, 9'h041, 8, 0, 1'b0, 1'b1, 1'b1, 1, 0);
    check("t1_count", 32'(vcnt[0] - base), 32'd1);
    check("t1_data",  32'(ldata[0]), 32'h41);
    check("t1_pe",    32'(lpe[0]),   32'd0);
    check("t1_fe",    32'(lfe[0]),   32'd0);
    check("t1_brk",   32'(lbrk[0]),  32'd0);
    check("t1_busy_after", 32'(busy_after[0]), 32'd0);

    // 2: 8E1 0x53 (four ones, even parity bit 0); first with bad parity 1
    base = vcnt[1];
    send(1, 9'h053, 8, 1, 1'b1, 1'b1, 1'b1, 1, 0);
    check("t2a_count", 32'(vcnt[1] - base), 32'd1);
    check("t2a_data",  32'(ldata[1]), 32'h53);
    check("t2a_pe",    32'(lpe[1]),   32'd1);
    check("t2a_fe",    32'(lfe[1]),   32'd0);
    send(1, 9'h053, 8, 1, 1'b0, 1'b1, 1'b1, 1, 0);
    check("t2b_count", 32'(vcnt[1] - base), 32'd2);
    check("t2b_pe",    32'(lpe[1]),   32'd0);

    // 3: 3-cycle low glitch, then 0x2A
    base = vcnt[0];
    rx[0] = 1'b0;
    repeat (3) tick();
    rx[0] = 1'b1;
    repeat (2) tick();
    check("t3_busy_rise", 32'(w_busy[0]), 32'd1);
    repeat (10) tick();
    check("t3_busy_fall", 32'(w_busy[0]), 32'd0);
    check("t3_no_valid",  32'(vcnt[0] - base), 32'd0);
    send(0, 9'h02A, 8, 0, 1'b0, 1'b1, 1'b1, 1, 0);
    check("t3_count", 32'(vcnt[0] - base), 32'd1);
    check("t3_data",  32'(ldata[0]), 32'h2A);
    check("t3_fe",    32'(lfe[0]),   32'd0);

    // 4: 0xA5 with a glitch at mid-bit of every data bit
    base = vcnt[0];
    send(0, 9'h0A5, 8, 0, 1'b0, 1'b1, 1'b1, 1, 1);
    check("t4_count", 32'(vcnt[0] - base), 32'd1);
    check("t4_data",  32'(ldata[0]), 32'hA5);
    check("t4_flags", {29'd0, lpe[0], lfe[0], lbrk[0]}, 32'd0);

    // 5: break (20 bit times low), then 0x7E
    base = vcnt[0];
    rx[0] = 1'b0;
    repeat (200) tick();
    check("t5_count_low", 32'(vcnt[0] - base), 32'd1);
    check("t5_data",  32'(ldata[0]), 32'h00);
    check("t5_fe",    32'(lfe[0]),   32'd1);
    check("t5_brk",   32'(lbrk[0]),  32'd1);
    check("t5_pe",    32'(lpe[0]),   32'd0);
    rx[0] = 1'b1;
    repeat (20) tick();
    send(0, 9'h07E, 8, 0, 1'b0, 1'b1, 1'b1, 1, 0);
    check("t5_count", 32'(vcnt[0] - base), 32'd2);
    check("t5_data2", 32'(ldata[0]), 32'h7E);
    check("t5_flags2", {29'd0, lpe[0], lfe[0], lbrk[0]}, 32'd0);

    // 6a: 7E2 0x35 (four ones, parity 0), second stop bit low
    base = vcnt[2];
    send(2, 9'h035, 7, 1, 1'b0, 1'b1, 1'b0, 2, 0);
    check("t6a_count", 32'(vcnt[2] - base), 32'd1);
    check("t6a_data",  32'(ldata[2]), 32'h35);
    check("t6a_fe",    32'(lfe[2]),   32'd1);
    check("t6a_brk",   32'(lbrk[2]),  32'd0);
    check("t6a_pe",    32'(lpe[2]),   32'd0);

    // 6b: reset during data bit 3 of an 8N1 frame, then 0x0F
    base = vcnt[0];
    drive_bit(0, 1'b0, 1'b0);
    drive_bit(0, 1'b0, 1'b0);
    drive_bit(0, 1'b0, 1'b0);
    drive_bit(0, 1'b0, 1'b0);
    rx[0] = 1'b1;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("t6b_rst_busy", 32'(w_busy[0]), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    send(0, 9'h00F, 8, 0, 1'b0, 1'b1, 1'b1, 1, 0);
    check("t6b_count", 32'(vcnt[0] - base), 32'd1);
    check("t6b_data",  32'(ldata[0]), 32'h0F);
    check("t6b_flags", {29'd0, lpe[0], lfe[0], lbrk[0]}, 32'd0);

    check("stray_flags", 32'(stray[0] + stray[1] + stray[2]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
